// File: rtl/w_ram_banked_pkg.sv
// Shared defaults, row type and clear-engine state encoding for the banked weight store.
package w_ram_banked_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_MAX_DEPTH   = 4;
  localparam int DEF_MAX_NEURONS = 8;
  localparam int DEF_WEIGHT_INIT = 0;

  typedef logic [DEF_MAX_NEURONS-1:0][DEF_DATA_W-1:0] row_t;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/w_ram_clear_seq.sv
// Sequential row-clear engine: walks every row once after reset or a clear request.
module w_ram_clear_seq
  import w_ram_banked_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE: begin
          if (start_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/w_ram_banked.sv
// Banked per-(layer,neuron) weight row store with masked writes, registered reads and self-clear.
// Optional word parity (stored, checked, injectable) under W_RAM_PARITY_EN.
module w_ram_banked
  import w_ram_banked_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_DEPTH   = DEF_MAX_DEPTH,
  parameter int MAX_NEURONS = DEF_MAX_NEURONS,
  parameter int WEIGHT_INIT = DEF_WEIGHT_INIT,
  parameter int LAYER_W     = $clog2(MAX_DEPTH) + 1,
  parameter int NEURON_W    = $clog2(MAX_NEURONS) + 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          clr,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [LAYER_W-1:0]            req_layer,
  input  logic [NEURON_W-1:0]           req_neuron,
  input  logic [MAX_NEURONS-1:0]        req_wmask,
  input  logic [MAX_NEURONS*DATA_W-1:0] w_in,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [MAX_NEURONS*DATA_W-1:0] w_out,
  output logic                          addr_err,
  output logic                          busy
`ifdef W_RAM_PARITY_EN
  ,
  output logic [MAX_NEURONS-1:0]        par_err,
  input  logic                          inj_par
`endif
);

  localparam int ROWS  = MAX_DEPTH * MAX_NEURONS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(WEIGHT_INIT);

  typedef logic [MAX_NEURONS-1:0][DATA_W-1:0] row_w_t;

  row_w_t            mem_q [ROWS];
  row_w_t            w_in_row;
  row_w_t            w_out_q, w_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              clr_busy;
  logic              clr_done;
  logic [ROW_W-1:0]  clr_row;
  logic [ROW_W-1:0]  req_row;
  logic              in_range;
  logic              accept;
  logic              wr_hit;
  logic              rd_hit;

  w_ram_clear_seq #(
    .ROWS  (ROWS),
    .CNT_W (ROW_W)
  ) u_clear_seq (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (clr),
    .busy_o  (clr_busy),
    .cnt_o   (clr_row),
    .done_o  (clr_done)
  );

  assign w_in_row  = w_in;
  assign busy      = clr_busy;
  assign req_ready = !clr_busy && !clr && (!rd_valid_q || rd_ready);
  assign accept    = req_valid && req_ready;
  assign in_range  = (int'(req_layer) < MAX_DEPTH) && (int'(req_neuron) < MAX_NEURONS);
  // Flat row index is only meaningful when in_range; upper index bits reach nothing else.
  assign req_row   = ROW_W'(int'(req_layer) * MAX_NEURONS + int'(req_neuron));
  assign wr_hit    = accept && req_we && in_range;
  assign rd_hit    = accept && !req_we && in_range;

`ifdef W_RAM_PARITY_EN
  logic [MAX_NEURONS-1:0] par_mem_q [ROWS];
  logic [MAX_NEURONS-1:0] par_err_q, par_err_d;
`endif

  always_ff @(posedge CLK) begin
    if (clr_busy) begin
      mem_q[clr_row] <= {MAX_NEURONS{INIT_WORD}};
`ifdef W_RAM_PARITY_EN
      par_mem_q[clr_row] <= {MAX_NEURONS{^INIT_WORD}};
`endif
    end else if (wr_hit) begin
      for (int unsigned k = 0; k < MAX_NEURONS; k++) begin
        if (req_wmask[k]) begin
          mem_q[req_row][k] <= w_in_row[k];
`ifdef W_RAM_PARITY_EN
          par_mem_q[req_row][k] <= (^w_in_row[k]) ^ (inj_par && (k == 0));
`endif
        end
      end
`ifdef W_RAM_PARITY_EN
      // Injection on an unwritten word 0 flips whatever parity is already stored.
      if (inj_par && !req_wmask[0]) begin
        par_mem_q[req_row][0] <= ~par_mem_q[req_row][0];
      end
`endif
    end
  end

  always_comb begin
    rd_valid_d = rd_valid_q;
    w_out_d    = w_out_q;
    addr_err_d = accept && !in_range;
`ifdef W_RAM_PARITY_EN
    par_err_d  = par_err_q;
`endif
    if (rd_hit) begin
      rd_valid_d = 1'b1;
      w_out_d    = mem_q[req_row];
`ifdef W_RAM_PARITY_EN
      for (int unsigned k = 0; k < MAX_NEURONS; k++) begin
        par_err_d[k] = (^mem_q[req_row][k]) ^ par_mem_q[req_row][k];
      end
`endif
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid_q <= 1'b0;
      w_out_q    <= '0;
      addr_err_q <= 1'b0;
`ifdef W_RAM_PARITY_EN
      par_err_q  <= '0;
`endif
    end else begin
      rd_valid_q <= rd_valid_d;
      w_out_q    <= w_out_d;
      addr_err_q <= addr_err_d;
`ifdef W_RAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rd_valid = rd_valid_q;
  assign w_out    = w_out_q;
  assign addr_err = addr_err_q;
`ifdef W_RAM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_w_ram_banked.sv
// Self-checking bench for w_ram_banked: directed steps plus random traffic against a row-level model.
module tb_w_ram_banked;
  import w_ram_banked_pkg::*;

  localparam int DW   = 16;
  localparam int MD   = 4;
  localparam int MN   = 8;
  localparam int ROWS = MD * MN;
  localparam logic [DW-1:0] WI = 16'h5A3C;

  logic           CLK;
  logic           RST_N;
  logic           clr;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [2:0]     req_layer;
  logic [3:0]     req_neuron;
  logic [MN-1:0]  req_wmask;
  logic [127:0]   w_in;
  logic           rd_valid;
  logic           rd_ready;
  logic [127:0]   w_out;
  logic           addr_err;
  logic           busy;
`ifdef W_RAM_PARITY_EN
  logic [MN-1:0]  par_err;
  logic           inj_par;
`endif

  w_ram_banked #(
    .DATA_W      (DW),
    .MAX_DEPTH   (MD),
    .MAX_NEURONS (MN),
    .WEIGHT_INIT (int'(WI))
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_layer  (req_layer),
    .req_neuron (req_neuron),
    .req_wmask  (req_wmask),
    .w_in       (w_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .w_out      (w_out),
    .addr_err   (addr_err),
    .busy       (busy)
`ifdef W_RAM_PARITY_EN
    ,
    .par_err    (par_err),
    .inj_par    (inj_par)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Row-level reference model
  row_t     m_mem [ROWS];
  bit [7:0] m_par [ROWS];
  bit       m_busy;
  int       m_cnt;
  bit       m_rdv;
  row_t     m_wout;
  bit       m_aerr;
  bit [7:0] m_perr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] wparity(input row_t r);
    bit [7:0] p;
    for (int k = 0; k < MN; k++) p[k] = ^r[k];
    return p;
  endfunction

  // One clock: check ready before the edge, advance the model, check registered outputs after it.
  task automatic tick();
    bit   exp_ready, acc, inr;
    int   idx;
    row_t wr;
    #1;
    exp_ready = !m_busy && !clr && (!m_rdv || rd_ready);
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    acc = req_valid && exp_ready;
    inr = (int'(req_layer) < MD) && (int'(req_neuron) < MN);
    idx = int'(req_layer) * MN + int'(req_neuron);
    wr  = w_in;
    if (m_busy) begin
      m_mem[m_cnt] = {MN{WI}};
      m_par[m_cnt] = {MN{^WI}};
      m_cnt++;
      if (m_cnt == ROWS) m_busy = 1'b0;
    end else if (clr) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    m_aerr = acc && !inr;
    if (acc && inr && !req_we) begin
      m_rdv  = 1'b1;
      m_wout = m_mem[idx];
      m_perr = wparity(m_mem[idx]) ^ m_par[idx];
    end else if (rd_ready) begin
      m_rdv = 1'b0;
    end
    if (acc && inr && req_we) begin
      for (int k = 0; k < MN; k++) begin
        if (req_wmask[k]) begin
          m_mem[idx][k] = wr[k];
          m_par[idx][k] = ^wr[k];
        end
      end
`ifdef W_RAM_PARITY_EN
      if (inj_par) m_par[idx][0] = ~m_par[idx][0];
`endif
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("rd_valid", 128'(rd_valid), 128'(m_rdv));
    chk("w_out", w_out, m_wout);
    chk("addr_err", 128'(addr_err), 128'(m_aerr));
    chk("busy", 128'(busy), 128'(m_busy));
`ifdef W_RAM_PARITY_EN
    chk("par_err", 128'(par_err), 128'(m_perr));
`endif
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    #2;
    m_busy = 1'b1; m_cnt = 0; m_rdv = 1'b0; m_wout = '0; m_aerr = 1'b0; m_perr = '0;
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_w_out", w_out, 128'(0));
    chk("rst_addr_err", 128'(addr_err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic count_sweep(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk(tag, 128'(n), 128'(ROWS));
  endtask

  task automatic set_req(input bit valid, input bit we, input int layer, input int neuron,
                         input bit [7:0] mask, input row_t data);
    req_valid  = valid;
    req_we     = we;
    req_layer  = 3'(layer);
    req_neuron = 4'(neuron);
    req_wmask  = mask;
    w_in       = data;
  endtask

  row_t snap [ROWS];
  row_t tmp, expr;

  initial begin
    RST_N = 1'b0; clr = 1'b0; rd_ready = 1'b1;
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
`ifdef W_RAM_PARITY_EN
    inj_par = 1'b0;
`endif
    for (int i = 0; i < ROWS; i++) begin m_mem[i] = '0; m_par[i] = '0; end
    @(negedge CLK);
    apply_reset();

    // Clear after reset with a read held pending
    set_req(1'b1, 1'b0, 3, 7, 8'h00, '0);
    count_sweep("init_sweep_len");
    tick();
    chk("init_row37", w_out, {MN{WI}});

    // Masked write then immediate readback
    for (int k = 0; k < MN; k++) tmp[k] = 16'(16'h0100 + k);
    set_req(1'b1, 1'b1, 1, 2, 8'b1010_0101, tmp);
    tick();
    set_req(1'b1, 1'b0, 1, 2, 8'h00, '0);
    tick();
    for (int k = 0; k < MN; k++) expr[k] = (8'b1010_0101 >> k) & 1 ? 16'(16'h0100 + k) : WI;
    chk("masked_row", w_out, expr);
    chk("masked_valid", 128'(rd_valid), 128'(1));
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
    tick();

    // Backpressure: three distinct rows, consumer stalled
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < MN; k++) tmp[k] = 16'($urandom);
      set_req(1'b1, 1'b1, 0, n, 8'hFF, tmp);
      tick();
    end
    rd_ready = 1'b0;
    set_req(1'b1, 1'b0, 0, 0, 8'h00, '0);
    tick();
    set_req(1'b1, 1'b0, 0, 1, 8'h00, '0);
    repeat (3) tick();
    chk("bp_hold_row0", w_out, m_mem[0]);
    rd_ready = 1'b1;
    tick();
    chk("bp_row1", w_out, m_mem[1]);
    set_req(1'b1, 1'b0, 0, 2, 8'h00, '0);
    tick();
    chk("bp_row2", w_out, m_mem[2]);
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
    tick();

    // Out-of-range read and write, then full readback
    for (int i = 0; i < ROWS; i++) snap[i] = m_mem[i];
    set_req(1'b1, 1'b0, 4, 0, 8'h00, '0);
    tick();
    chk("oor_rd_err", 128'(addr_err), 128'(1));
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
    tick();
    chk("oor_rd_pulse_end", 128'(addr_err), 128'(0));
    set_req(1'b1, 1'b1, 0, 8, 8'hFF, {4{32'hDEAD_BEEF}});
    tick();
    chk("oor_wr_err", 128'(addr_err), 128'(1));
    chk("oor_wr_novalid", 128'(rd_valid), 128'(0));
    for (int i = 0; i < ROWS; i++) begin
      set_req(1'b1, 1'b0, i / MN, i % MN, 8'h00, '0);
      tick();
      chk("readback", w_out, snap[i]);
    end
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
    tick();

    // Soft clear of a written row
    set_req(1'b1, 1'b1, 2, 5, 8'hFF, {4{32'h1234_8765}});
    tick();
    set_req(1'b1, 1'b0, 2, 5, 8'h00, '0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_sweep("clr_sweep_len");
    tick();
    chk("clr_row25", w_out, {MN{WI}});

    // Async reset in the middle of a sweep
    set_req(1'b0, 1'b0, 0, 0, 8'h00, '0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 40 && m_cnt != 10; i++) tick();
    apply_reset();
    count_sweep("rst_sweep_len");

`ifdef W_RAM_PARITY_EN
    for (int k = 0; k < MN; k++) tmp[k] = 16'($urandom);
    inj_par = 1'b1;
    set_req(1'b1, 1'b1, 1, 1, 8'hFF, tmp);
    tick();
    inj_par = 1'b0;
    set_req(1'b1, 1'b0, 1, 1, 8'h00, '0);
    tick();
    chk("par_inject", 128'(par_err), 128'(8'b0000_0001));
    set_req(1'b1, 1'b1, 1, 1, 8'hFF, tmp);
    tick();
    set_req(1'b1, 1'b0, 1, 1, 8'h00, '0);
    tick();
    chk("par_clean", 128'(par_err), 128'(0));
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < MN; k++) tmp[k] = 16'($urandom);
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 5), $urandom_range(0, 9), 8'($urandom), tmp);
      rd_ready = $urandom_range(0, 3) != 0;
      clr      = $urandom_range(0, 59) == 0;
`ifdef W_RAM_PARITY_EN
      inj_par  = $urandom_range(0, 7) == 0;
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/w_ram_banked.md
Name: w_ram_banked

Overview:
- Parametrised successor to the per-layer weight store.
- Holds one weight row (MAX_NEURONS words of DATA_W) per (layer, neuron) pair.
- Adds a valid/ready request handshake, per-word write mask, a registered read channel with backpressure, out-of-range error reporting and a sequential self-clear engine.
- Sits between the weight loader (writes) and the neuron compute datapath (reads).

Parameters:
- DATA_W, 16, width of one weight word (signed fixed-point, opaque to this block).
- MAX_DEPTH, 4, number of layers stored.
- MAX_NEURONS, 8, neurons per layer; also words per row.
- WEIGHT_INIT, 0, value written to every word by the clear engine.
- LAYER_W, $clog2(MAX_DEPTH)+1, layer index width; the extra bit allows out-of-range detection.
- NEURON_W, $clog2(MAX_NEURONS)+1, neuron index width.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous active-low reset.
- clr  in  1  soft clear request; sampled in IDLE only.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_layer  in  LAYER_W  layer index.
- req_neuron  in  NEURON_W  neuron index.
- req_wmask  in  MAX_NEURONS  per-word write enable.
- w_in  in  MAX_NEURONS*DATA_W  write row; word k is w_in[k*DATA_W +: DATA_W].
- rd_valid  out  1  w_out holds read data.
- rd_ready  in  1  consumer accepts w_out.
- w_out  out  MAX_NEURONS*DATA_W  read row.
- addr_err  out  1  one-cycle pulse: the accepted request was out of range.
- busy  out  1  clear engine running.

Behaviour:
- Reset (async, RST_N=0):
  - State = INIT, row counter = 0.
  - rd_valid=0, w_out=0, addr_err=0, busy=1, req_ready=0.
- FSM has two states, INIT and IDLE.
- INIT:
  - Each cycle, writes WEIGHT_INIT to every word of row[cnt] (layer = cnt / MAX_NEURONS, neuron = cnt % MAX_NEURONS), then cnt++.
  - After row MAX_DEPTH*MAX_NEURONS-1 is written, goes to IDLE on the next edge; busy falls with the transition.
  - A full sweep takes MAX_DEPTH*MAX_NEURONS cycles.
- IDLE:
  - If clr=1, goes to INIT with cnt=0; any request that cycle is not accepted.
  - Pending rd_valid data is kept through a clear.
- req_ready = (state==IDLE) && !clr && (!rd_valid || rd_ready).
- Accept occurs on req_valid && req_ready.
- Range check: req_layer < MAX_DEPTH and req_neuron < MAX_NEURONS.
- Accepted in-range write:
  - Words with req_wmask[k]=1 take w_in word k at this edge; other words are unchanged.
  - No response is generated.
- Accepted in-range read:
  - The row is registered into w_out and rd_valid=1 at this edge, so latency is 1 cycle.
  - A read of the row written in the previous cycle returns the new data.
- Accepted out-of-range request (read or write):
  - Memory is unchanged and no rd_valid is produced.
  - addr_err=1 for exactly the next cycle.
- Read channel:
  - rd_valid stays high and w_out stays stable until rd_ready=1.
  - rd_valid && rd_ready with no new read accepted: rd_valid goes to 0 next cycle; w_out holds its last value.
  - rd_ready=1 together with a new accepted read: back-to-back, one row per cycle, no bubble.
- Reset asserted mid-INIT or mid-transfer: everything returns to reset values and the sweep restarts from row 0.
- Unused upper index bits feed only the range check.

Optional Feature:
- Macro: W_RAM_PARITY_EN.
- When defined:
  - Each row stores one extra even-parity bit per word, computed on write and during INIT.
  - On read, parity is checked; output port par_err (MAX_NEURONS bits) is registered alongside w_out with the same valid/hold rules.
  - Test hook input inj_par (1 bit, write-only): when high during a write, the stored parity of word 0 is inverted.
- When undefined: no parity storage, and the par_err and inj_par ports do not exist.

Decomposition:
- Shared package holds:
  - DATA_W, MAX_DEPTH, MAX_NEURONS and WEIGHT_INIT defaults.
  - The row typedef (array of MAX_NEURONS DATA_W words).
  - The state enum {INIT, IDLE}.
- One natural sub-module: w_ram_clear_seq. It holds the INIT row counter, the busy output and the done pulse, and is reused by the bias RAM.

Test Plan:
- Clear after reset: release RST_N, hold req_valid=1 → req_ready=0 and busy=1 for exactly MAX_DEPTH*MAX_NEURONS=32 cycles; then a read of (3,7) returns all words = WEIGHT_INIT.
- Masked write and readback: write layer 1, neuron 2, w_in words k=0..7 = 0x0100+k, mask 8'b1010_0101; read in the next cycle → words 0,2,5,7 are new, others = WEIGHT_INIT; rd_valid rises 1 cycle after accept.
- Backpressure: issue reads (0,0),(0,1),(0,2) with rd_ready=0 for 3 cycles → req_ready=0 after the first accept and w_out stable; raise rd_ready → rows delivered on consecutive cycles in order.
- Out of range: read with layer=4, then write with neuron=8 → addr_err pulses 1 cycle each, no rd_valid, and a subsequent full readback matches the memory before the attempt.
- Soft clear and async reset: write a nonzero row, pulse clr in IDLE → busy for 32 cycles, then row = WEIGHT_INIT; assert RST_N=0 at sweep row 10 → sweep restarts and busy lasts a full 32 cycles.
- W_RAM_PARITY_EN: write with inj_par=1, then read → par_err = 8'b0000_0001; write the same row with inj_par=0, then read → par_err=0.
